// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises one 64-bit read/write frame
// per req/done handshake, MSB first, with PHY sampling on rising MDC.
module mdio_master #(
    parameter int C_mdc_half = 40,
    parameter int C_preamble = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        rd_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int NB      = C_preamble + 32;
    localparam int HW      = $clog2(C_mdc_half + 1);
    localparam int BW      = $clog2(NB + 1);
    localparam int OE_BITS = C_preamble + 14;
    localparam int TA2     = C_preamble + 15;

    localparam logic [HW-1:0] H_LAST = HW'(C_mdc_half - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NB - 1);
    localparam logic [BW-1:0] B_TA2  = BW'(TA2);
    localparam logic [BW-1:0] B_OE   = BW'(OE_BITS);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t          state_q;
    logic [NB-1:0]   sh_q;
    logic [HW-1:0]   hcnt_q;
    logic [BW-1:0]   bitcnt_q;
    logic            wr_q;
    logic            err_q;
    logic [15:0]     rsh_q;
    logic            busy_q;
    logic            done_q;
    logic [15:0]     rdata_q;
    logic            rd_err_q;
    logic            mdc_q;
    logic            mdio_o_q;
    logic            mdio_oe_q;

    logic [NB-1:0]   frame_d;
    logic [15:0]     rsh_d;
    logic [BW-1:0]   bitnxt_d;
    logic            bit_end_d;

    always_comb begin
        frame_d = '0;
        if (wr) begin
            frame_d = {{C_preamble{1'b1}}, 2'b01, 2'b01,
                       phy_addr, reg_addr, 2'b10, wdata};
        end else begin
            // TA and data are released to the PHY; pad with idle ones
            frame_d = {{C_preamble{1'b1}}, 2'b01, 2'b10,
                       phy_addr, reg_addr, 2'b11, 16'hFFFF};
        end
        rsh_d     = {rsh_q[14:0], mdio_i};
        bitnxt_d  = bitcnt_q + BW'(1);
        bit_end_d = (state_q == S_SHIFT) && mdc_q && (hcnt_q == H_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            hcnt_q    <= '0;
            bitcnt_q  <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            rsh_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            rd_err_q  <= 1'b0;
            mdc_q     <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    mdc_q     <= 1'b0;
                    mdio_o_q  <= 1'b1;
                    mdio_oe_q <= 1'b0;
                    if (req) begin
                        state_q   <= S_SHIFT;
                        busy_q    <= 1'b1;
                        wr_q      <= wr;
                        sh_q      <= {frame_d[NB-2:0], 1'b0};
                        mdio_o_q  <= frame_d[NB-1];
                        mdio_oe_q <= 1'b1;
                        hcnt_q    <= '0;
                        bitcnt_q  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_q <= '0;
                        mdc_q  <= ~mdc_q;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                    if (bit_end_d) begin
                        if (!wr_q && bitcnt_q == B_TA2) begin
                            err_q <= mdio_i;
                        end
                        if (!wr_q && bitcnt_q > B_TA2) begin
                            rsh_q <= rsh_d;
                        end
                        if (bitcnt_q == B_LAST) begin
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            mdc_q     <= 1'b0;
                            mdio_o_q  <= 1'b1;
                            mdio_oe_q <= 1'b0;
                            if (wr_q) begin
                                rd_err_q <= 1'b0;
                            end else begin
                                rdata_q  <= rsh_d;
                                rd_err_q <= err_q;
                            end
                        end else begin
                            bitcnt_q  <= bitnxt_d;
                            mdio_o_q  <= sh_q[NB-1];
                            sh_q      <= {sh_q[NB-2:0], 1'b0};
                            mdio_oe_q <= wr_q || (bitnxt_d < B_OE);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign rd_err  = rd_err_q;
    assign mdc     = mdc_q;
    assign mdio_o  = mdio_o_q;
    assign mdio_oe = mdio_oe_q;

endmodule
